// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and frame constants.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_START  = S_START,
        ST_DATA   = S_DATA,
        ST_PARITY = S_PARITY,
        ST_STOP   = S_STOP
    } uart_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; DEPTH must be a power of two.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_data,
    input  logic                     i_pop,
    output logic [7:0]               o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_ONE;
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_ONE;
        end
    end

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_tx_stream.sv
// 8N1 UART transmitter with a byte FIFO and runtime bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state   | meaning
// IDLE    | line high, pop next byte when enabled
// START   | start bit (low) for P cycles
// DATA    | data bits LSB first, P cycles each
// PARITY  | even parity bit (UART_TX_PARITY_EN only)
// STOP    | stop bit (high), frame_done in last cycle
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_tx_en,
    input  logic [DIV_W-1:0]         i_clk_div,
    input  logic [7:0]               i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic                     o_ser_tx,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic                     o_frame_done
);

    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    uart_state_e            r_state;
    logic [DIV_W-1:0]       r_period;
    logic [DIV_W-1:0]       r_div_cnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;

    logic                   w_pop;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_bit_end;
    logic                   w_ser_tx;
    logic [7:0]             w_fifo_data;
    logic [DIV_W-1:0]       w_period_in;
    logic [$clog2(DEPTH):0] w_count;

    uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (i_in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_push      = i_in_valid && !w_full;
    assign w_pop       = (r_state == ST_IDLE) && i_tx_en && !w_empty;
    assign w_period_in = (i_clk_div == '0) ? DIV_ONE : i_clk_div;
    assign w_bit_end   = (r_div_cnt == r_period - DIV_ONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_period  <= '0;
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else if (r_state == ST_IDLE) begin
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            if (w_pop) begin
                r_state  <= ST_START;
                r_period <= w_period_in;
                r_shift  <= w_fifo_data;
            end
        end else if (!w_bit_end) begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end else begin
            r_div_cnt <= '0;
            case (r_state)
                ST_START: r_state <= ST_DATA;
                ST_DATA: begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        r_state <= ST_PARITY;
`else
                        r_state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: r_state <= ST_STOP;
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ser_tx = UART_IDLE_LEVEL;
        case (r_state)
            ST_START: w_ser_tx = 1'b0;
            ST_DATA:  w_ser_tx = r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_ser_tx = even_parity(r_shift);
`endif
            default:  w_ser_tx = UART_IDLE_LEVEL;
        endcase
    end

    assign o_ser_tx     = w_ser_tx;
    assign o_in_ready   = !w_full;
    assign o_fifo_count = w_count;
    assign o_busy       = (r_state != ST_IDLE) || (w_count != '0);
    assign o_frame_done = (r_state == ST_STOP) && w_bit_end;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: queued expected frames are decoded off ser_tx and compared.
`timescale 1ns/1ps
module tb_uart_tx_stream;

    localparam int DEPTH = 8;
    localparam int DIV_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    typedef struct {
        logic [7:0] data;
        int         period;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tx_en = 1'b0;
    logic [DIV_W-1:0] clk_div = '0;
    logic [7:0]       in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             ser_tx;
    logic             busy;
    logic [CW-1:0]    fifo_count;
    logic             frame_done;

    exp_t sb_q[$];
    int   gap_hist[$];
    int   len_hist[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   frames_seen = 0;
    int   last_len = 0;
    logic last_busy_after = 1'b1;
    logic last_parity = 1'b0;
    logic mon_en = 1'b0;
    logic mon_busy = 1'b0;

    uart_tx_stream #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tx_en      (tx_en),
        .i_clk_div    (clk_div),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .o_ser_tx     (ser_tx),
        .o_busy       (busy),
        .o_fifo_count (fifo_count),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at #1 after a rising edge; returns #1 after the handshake edge.
    task automatic push_byte(input logic [7:0] d, input int p, output logic acc);
        exp_t e;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        acc = in_ready;
        if (acc) begin
            e.data   = d;
            e.period = p;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            done = (sb_q.size() == 0) && !mon_busy && !busy;
        end
        chk({tag, "_drain"}, done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Frame decoder: every cycle of every bit is compared with the expected line level.
    initial begin
        exp_t             e;
        logic [NBITS-1:0] exp_bits;
        logic [7:0]       got;
        int               errs;
        int               derr;
        int               start;
        int               prev_end;
        logic             aborted;
        prev_end = -100;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && ser_tx == 1'b0) begin
                mon_busy = 1'b1;
                aborted  = 1'b0;
                start    = cyc;
                if (sb_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                    e.data   = 8'h00;
                    e.period = 1;
                end else begin
                    e = sb_q.pop_front();
                end
`ifdef UART_TX_PARITY_EN
                exp_bits = {1'b1, ^e.data, e.data, 1'b0};
`else
                exp_bits = {1'b1, e.data, 1'b0};
`endif
                errs = 0;
                derr = 0;
                got  = '0;
                for (int b = 0; b < NBITS && !aborted; b++) begin
                    for (int c = 0; c < e.period && !aborted; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!mon_en || !rst_n) begin
                            aborted = 1'b1;
                        end else begin
                            if (ser_tx !== exp_bits[b]) errs++;
                            if (frame_done !== (b == NBITS-1 && c == e.period-1)) derr++;
                            if (c == e.period/2 && b >= 1 && b <= 8) got[b-1] = ser_tx;
                            if (c == e.period/2 && b == 9 && NBITS == 11) last_parity = ser_tx;
                        end
                    end
                end
                if (!aborted) begin
                    gap_hist.push_back(start - prev_end - 1);
                    prev_end = cyc;
                    last_len = cyc - start + 1;
                    len_hist.push_back(last_len);
                    chk("frame_byte", got, e.data);
                    chk("frame_shape", errs, 0);
                    chk("frame_done_pos", derr, 0);
                    @(negedge clk);
                    last_busy_after = busy;
                    chk("gap_idle_high", ser_tx, 1'b1);
                    frames_seen++;
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic acc;
        int   base;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ser_tx", ser_tx, 1'b1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte 0x55 at P=4, plus push-to-start latency
        clk_div = 16'd4;
        tx_en   = 1'b1;
        push_byte(8'h55, 4, acc);
        chk("lat_count_one", fifo_count, 1);
        chk("lat_line_high", ser_tx, 1'b1);
        @(posedge clk);
        #1;
        chk("lat_line_low", ser_tx, 1'b0);
        chk("lat_count_zero", fifo_count, 0);
        wait_drain(200, "single");
        chk("single_len", last_len, NBITS*4);
        chk("single_busy_after", last_busy_after, 1'b0);

        // Back-to-back frames with one idle clock between them
        clk_div = 16'd5;
        base = frames_seen;
        push_byte(8'h41, 5, acc);
        push_byte(8'h42, 5, acc);
        chk("pushpop_count", fifo_count, 1);
        push_byte(8'h0A, 5, acc);
        wait_drain(600, "b2b");
        chk("b2b_frames", frames_seen - base, 3);
        chk("b2b_gap1", gap_hist[gap_hist.size()-2], 1);
        chk("b2b_gap2", gap_hist[gap_hist.size()-1], 1);

        // Fill FIFO with transmit disabled, ninth byte must be refused
        tx_en   = 1'b0;
        clk_div = 16'd2;
        base = frames_seen;
        for (int i = 0; i < 9; i++) begin
            push_byte(8'h80 + 8'(i), 2, acc);
            if (i == 7) chk("full_ready_low", in_ready, 1'b0);
            if (i == 8) chk("ninth_rejected", acc, 1'b0);
        end
        chk("full_count", fifo_count, DEPTH);
        chk("full_busy", busy, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("disabled_no_tx", frames_seen - base, 0);
        tx_en = 1'b1;
        wait_drain(1000, "full");
        chk("full_frames", frames_seen - base, 8);

        // Divisor 0 behaves as 1
        clk_div = '0;
        push_byte(8'h3C, 1, acc);
        wait_drain(100, "div0");
        chk("div0_len", last_len, NBITS);

        // Divisor change mid-frame applies only to the next frame
        clk_div = 16'd4;
        push_byte(8'h12, 4, acc);
        push_byte(8'h34, 8, acc);
        clk_div = 16'd8;
        wait_drain(600, "divchg");
        chk("divchg_len_first", len_hist[len_hist.size()-2], NBITS*4);
        chk("divchg_len_second", len_hist[len_hist.size()-1], NBITS*8);

        // Asynchronous reset during data bit 3
        clk_div = 16'd4;
        push_byte(8'hC3, 4, acc);
        push_byte(8'h99, 4, acc);
        repeat (17) @(posedge clk);
        #1;
        chk("pre_rst_line_bit3", ser_tx, 1'b0);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rstmid_ser_tx", ser_tx, 1'b1);
        chk("rstmid_count", fifo_count, 0);
        chk("rstmid_busy", busy, 1'b0);
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        base = frames_seen;
        push_byte(8'hA5, 4, acc);
        wait_drain(200, "post_rst");
        chk("post_rst_frames", frames_seen - base, 1);

`ifdef UART_TX_PARITY_EN
        push_byte(8'h07, 4, acc);
        wait_drain(200, "parity");
        chk("parity_bit", last_parity, 1'b1);
        chk("parity_len", last_len, 44);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
